// File: rtl/fsm_seq_pkg.sv
// Shared types and defaults for the lockstep FSM sequencer.
// State encodings are plain constants so the enum and the RTL compare against the same values.
package fsm_seq_pkg;
  localparam int DEF_PAT_W = 16;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_LEN_W = $clog2(DEF_PAT_W) + 1;
  localparam logic [DEF_LEN_W-1:0] NO_ERR_IDX = '1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } seq_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/fsm_lockstep_sequencer.sv
// Serially drives a test pattern into two FSMs and compares their Q outputs in lockstep.
// Build option FSM_SEQ_STOP_ON_ERR_EN: end the run on the first mismatch.
module fsm_lockstep_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = $clog2(PAT_W) + 1,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             x,
  input  logic             q_a,
  input  logic             q_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [LEN_W-1:0] first_err_idx,
  output seq_state_t       dbg_state
);
  // Handshake: start is sampled only in IDLE; busy is high for exactly the
  // len RUN cycles; done pulses for the single DONE cycle that follows.
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] IDX_NONE = '1;

  logic [1:0]       r_state;
  logic [PAT_W-1:0] r_shift;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic [LEN_W-1:0] r_first;
  logic             r_x;
  logic             r_pass;

  logic             w_accept;
  logic             w_mis;
  logic             w_last;
  logic             w_end;
  logic [LEN_W-1:0] w_len_clamped;
  logic [CNT_W-1:0] w_cnt;

  assign w_len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
  assign w_accept      = (r_state == ST_IDLE) && start;
  assign w_mis         = (r_state == ST_RUN) && (q_a != q_b);
  assign w_last        = (r_idx == (r_len - LEN_W'(1)));

`ifdef FSM_SEQ_STOP_ON_ERR_EN
  assign w_end = w_last || w_mis;
`else
  assign w_end = w_last;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_first <= IDX_NONE;
      r_x     <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // Bit 0 goes straight to x; the shifter holds the remaining bits.
            r_shift <= pattern >> 1;
            r_len   <= w_len_clamped;
            r_idx   <= '0;
            r_first <= IDX_NONE;
            if (w_len_clamped == '0) begin
              r_state <= ST_DONE;
              r_x     <= 1'b0;
              r_pass  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_x     <= pattern[0];
              r_pass  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          r_shift <= r_shift >> 1;
          r_idx   <= r_idx + LEN_W'(1);
          if (w_mis && (r_first == IDX_NONE)) begin
            r_first <= r_idx;
          end
          if (w_end) begin
            r_state <= ST_DONE;
            r_x     <= 1'b0;
            // Include the mismatch sampled on this closing edge.
            r_pass  <= (w_cnt == '0) && !w_mis;
          end else begin
            r_x <= r_shift[0];
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_mis_cnt (
    .clk  (clk),
    .reset(reset),
    .i_clr(w_accept),
    .i_inc(w_mis),
    .o_cnt(w_cnt)
  );

  assign x             = r_x;
  assign busy          = (r_state == ST_RUN);
  assign done          = (r_state == ST_DONE);
  assign pass          = r_pass;
  assign mismatch_cnt  = w_cnt;
  assign first_err_idx = r_first;
  assign dbg_state     = seq_state_t'(r_state);
endmodule

// File: doc/fsm_lockstep_sequencer.md
Name: fsm_lockstep_sequencer

Overview:
Drives a serial test pattern on the shared X input of two FSM implementations (e.g. Mealy and Moore variants of the same detector) and compares their Q outputs every cycle in lockstep. Start/busy/done handshake; reports pass/fail, saturating mismatch count and the index of the first mismatch. Sits beside the FSM pair as their on-chip sequencer/self-checker.

Parameters:
PAT_W, 16, maximum pattern length in bits (>=2)
LEN_W, $clog2(PAT_W)+1, width of len and first_err_idx
CNT_W, 4, width of the saturating mismatch counter

Ports:
clk  in  1  rising-edge clock, shared with both FSMs
reset  in  1  synchronous, active-high reset
start  in  1  pulse: latch pattern/len, begin run; ignored while busy
pattern  in  PAT_W  bits shifted out LSB first
len  in  LEN_W  number of bits to apply (0..PAT_W; values >PAT_W clamp to PAT_W)
x  out  1  serial stimulus to both FSM X inputs
q_a  in  1  Q of FSM A
q_b  in  1  Q of FSM B
busy  out  1  high in RUN
done  out  1  one-cycle pulse on entry to DONE
pass  out  1  1 when last run had zero mismatches; held until next accepted start
mismatch_cnt  out  CNT_W  mismatches in last run, saturates at all-ones
first_err_idx  out  LEN_W  cycle index of first mismatch; all-ones if none

Behaviour:
- Reset: state IDLE; x=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_err_idx=all-ones. Reset mid-run aborts immediately, same values.
- States (enum in package): IDLE, RUN, DONE.
- IDLE: x=0. start=1 -> latch pattern into shift reg, len into remaining count, clear mismatch_cnt, first_err_idx=all-ones, idx=0. len=0 -> DONE with pass=1; else -> RUN.
- RUN: x is registered = shift_reg[0]; first bit visible the cycle after start. Each RUN cycle i (0..len-1): shift right, idx++, sample (q_a != q_b) at the closing edge of cycle i. On mismatch: mismatch_cnt+1 (saturating); if first_err_idx all-ones, load i. After cycle len-1 -> DONE; x returns 0.
- DONE: done=1 for exactly one cycle; pass=(mismatch_cnt==0 and no saturation overflow); -> IDLE next cycle.
- start in RUN or DONE: ignored, no effect on latched values. start in the same cycle as reset: reset wins.
- Latency: a run of len bits takes len+2 cycles start-to-done (1 latch, len RUN, 1 DONE).
- Outputs pass/mismatch_cnt/first_err_idx are stable from DONE until next accepted start.

Optional Feature:
FSM_SEQ_STOP_ON_ERR_EN: defined -> the first mismatch in RUN goes directly to DONE next cycle (mismatch_cnt=1, pass=0, x=0), remaining bits not applied. Undefined -> always runs all len bits and counts every mismatch.

Decomposition:
- Package fsm_seq_pkg: state enum typedef (IDLE, RUN, DONE), default PAT_W/CNT_W localparams, all-ones "no error" index constant.
- One sub-module: sat_counter (CNT_W-wide, synchronous clear, increment enable, saturate at max). Everything else in fsm_lockstep_sequencer.

Test Plan:
- Identical FSMs, pattern=16'b0000_0000_0110_1101, len=8 -> x sequence 1,0,1,1,0,1,1,0; done after 10 cycles; pass=1, mismatch_cnt=0, first_err_idx=all-ones.
- Force q_b inverted during cycles 3 and 5 only, len=8 -> pass=0, mismatch_cnt=2, first_err_idx=3 (with FSM_SEQ_STOP_ON_ERR_EN: mismatch_cnt=1, done 5 cycles after start).
- q_b permanently inverted, len=16, CNT_W=4 -> mismatch_cnt=15 (saturated), first_err_idx=0, pass=0.
- len=0 with start -> done pulse 1 cycle later, no RUN cycles, x stays 0, pass=1.
- Second start pulse mid-run and reset asserted at RUN cycle 4 -> start ignored; after reset busy=0, x=0, pass=0, mismatch_cnt=0, next start runs normally.
